// File: rtl/tdm_cal_sched.sv
// TDM calendar scheduler: walks a double-banked channel calendar and emits one
// registered channel select per enabled cycle, swapping banks only at a wrap.
module tdm_cal_sched #(
  parameter int CHAN_W = 5,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clockCore,
  input  logic              resetCore,
  input  logic              walkEn,
  input  logic              cfgWrEn,
  input  logic [IDX_W-1:0]  cfgWrAddr,
  input  logic [CHAN_W-1:0] cfgWrData,
  input  logic [IDX_W-1:0]  cfgEndPtr,
  input  logic              swapReq,
  output logic              cfgBusy,
  output logic              swapDone,
  output logic [CHAN_W-1:0] chanSel,
  output logic              chanVld,
  output logic              calStart,
  output logic [IDX_W-1:0]  walkIdx
);

  localparam logic [CHAN_W-1:0] IDLE     = {CHAN_W{1'b1}};
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE_S, PEND_S} swapState_t;

  swapState_t        state;
  swapState_t        nextState;
  logic [CHAN_W-1:0] calTable [2][DEPTH];
  logic              bankSel;
  logic [IDX_W-1:0]  actEnd;
  logic [IDX_W-1:0]  endClamped;
  logic [CHAN_W-1:0] curEntry;
  logic              atEnd;
  logic              swapPend;
  logic              swapHit;
  logic              wrOk;

  assign atEnd      = (walkIdx == actEnd);
  assign curEntry   = calTable[bankSel][walkIdx];
  assign endClamped = (32'(cfgEndPtr) >= 32'(DEPTH)) ? LAST_IDX : cfgEndPtr;
  assign wrOk       = cfgWrEn && !swapPend && (32'(cfgWrAddr) < 32'(DEPTH));
  assign cfgBusy    = swapPend;

  // Only the shadow bank (~bankSel) is ever written; both banks clear on reset.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          calTable[b][i] <= IDLE;
        end
      end
    end else if (wrOk) begin
      calTable[~bankSel][cfgWrAddr] <= cfgWrData;
    end
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state <= IDLE_S;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE_S:  if (swapReq) nextState = PEND_S;
      PEND_S:  if (walkEn && atEnd) nextState = IDLE_S;
      default: nextState = IDLE_S;
    endcase
  end

  always_comb begin
    swapPend = (state == PEND_S);
    swapHit  = (state == PEND_S) && walkEn && atEnd;
  end

  // The last old entry is still emitted in the swap cycle, so calendars never truncate.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      walkIdx  <= '0;
      bankSel  <= 1'b0;
      actEnd   <= '0;
      chanSel  <= IDLE;
      chanVld  <= 1'b0;
      calStart <= 1'b0;
      swapDone <= 1'b0;
    end else begin
      swapDone <= swapHit;
      if (walkEn) begin
        chanSel  <= curEntry;
        chanVld  <= (curEntry != IDLE);
        calStart <= (walkIdx == '0);
        if (swapHit) begin
          bankSel <= ~bankSel;
          actEnd  <= endClamped;
          walkIdx <= '0;
        end else if (atEnd) begin
          walkIdx <= '0;
        end else begin
          walkIdx <= walkIdx + IDX_W'(1);
        end
      end else begin
        chanVld  <= 1'b0;
        calStart <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_cal_sched.sv
// Bench for tdm_cal_sched: a calendar-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tdm_cal_sched;

  localparam int CHAN_W = 5;
  localparam int DEPTH  = 96;
  localparam int IDX_W  = 7;
  localparam logic [CHAN_W-1:0] IDLE = 5'h1F;

  logic              clockCore = 1'b0;
  logic              resetCore;
  logic              walkEn;
  logic              cfgWrEn;
  logic [IDX_W-1:0]  cfgWrAddr;
  logic [CHAN_W-1:0] cfgWrData;
  logic [IDX_W-1:0]  cfgEndPtr;
  logic              swapReq;
  logic              cfgBusy;
  logic              swapDone;
  logic [CHAN_W-1:0] chanSel;
  logic              chanVld;
  logic              calStart;
  logic [IDX_W-1:0]  walkIdx;

  int testsRun;
  int testsFailed;
  bit checkEn;

  tdm_cal_sched #(.CHAN_W(CHAN_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clockCore(clockCore),
    .resetCore(resetCore),
    .walkEn(walkEn),
    .cfgWrEn(cfgWrEn),
    .cfgWrAddr(cfgWrAddr),
    .cfgWrData(cfgWrData),
    .cfgEndPtr(cfgEndPtr),
    .swapReq(swapReq),
    .cfgBusy(cfgBusy),
    .swapDone(swapDone),
    .chanSel(chanSel),
    .chanVld(chanVld),
    .calStart(calStart),
    .walkIdx(walkIdx)
  );

  always #5 clockCore = ~clockCore;

  // Reference model: the active calendar is a list of mLen entries and mPos the
  // next one to play; a swap exchanges whole banks once the list has been played out.
  logic [CHAN_W-1:0] mAct [DEPTH];
  logic [CHAN_W-1:0] mShd [DEPTH];
  logic [CHAN_W-1:0] mTmp;
  int                mLen;
  int                mPos;
  bit                mPend;
  bit                mBusy;
  logic [CHAN_W-1:0] eSel;
  bit                eVld;
  bit                eStart;
  bit                eDone;

  always @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      for (int i = 0; i < DEPTH; i++) begin
        mAct[i] = IDLE;
        mShd[i] = IDLE;
      end
      mLen = 1; mPos = 0; mPend = 0;
      eSel = IDLE; eVld = 0; eStart = 0; eDone = 0;
    end else begin
      mBusy = mPend;
      eDone = 0;
      if (cfgWrEn && !mBusy && int'(cfgWrAddr) < DEPTH) mShd[cfgWrAddr] = cfgWrData;
      if (walkEn) begin
        eSel   = mAct[mPos];
        eVld   = (eSel != IDLE);
        eStart = (mPos == 0);
        if (mBusy && mPos == mLen - 1) begin
          for (int i = 0; i < DEPTH; i++) begin
            mTmp = mAct[i]; mAct[i] = mShd[i]; mShd[i] = mTmp;
          end
          mLen  = (int'(cfgEndPtr) >= DEPTH) ? DEPTH : int'(cfgEndPtr) + 1;
          mPos  = 0;
          mPend = 0;
          eDone = 1;
        end else begin
          mPos = (mPos + 1) % mLen;
        end
      end else begin
        eVld = 0;
        eStart = 0;
      end
      if (!mBusy && swapReq) mPend = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clockCore) begin
    if (resetCore && checkEn) begin
      checkOutput("model.chanSel", 32'(chanSel), 32'(eSel));
      checkOutput("model.chanVld", 32'(chanVld), 32'(eVld));
      checkOutput("model.calStart", 32'(calStart), 32'(eStart));
      checkOutput("model.walkIdx", 32'(walkIdx), 32'(mPos));
      checkOutput("model.cfgBusy", 32'(cfgBusy), 32'(mPend));
      checkOutput("model.swapDone", 32'(swapDone), 32'(eDone));
    end
  end

  task automatic applyStimulus(input logic walk, input logic wrEn, input int addr, input int data,
                               input logic swp);
    walkEn    = walk;
    cfgWrEn   = wrEn;
    cfgWrAddr = IDX_W'(addr);
    cfgWrData = CHAN_W'(data);
    swapReq   = swp;
    @(posedge clockCore);
    #1;
    cfgWrEn = 1'b0;
    swapReq = 1'b0;
  endtask

  task automatic waitSwapDone(input string tag);
    int n = 0;
    do begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
    end while (!swapDone && n < 200);
    checkOutput({tag, ".swapDone"}, 32'(swapDone), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".chanSel"}, 32'(chanSel), 32'h1F);
    checkOutput({tag, ".chanVld"}, 32'(chanVld), 32'd0);
    checkOutput({tag, ".calStart"}, 32'(calStart), 32'd0);
    checkOutput({tag, ".walkIdx"}, 32'(walkIdx), 32'd0);
    checkOutput({tag, ".cfgBusy"}, 32'(cfgBusy), 32'd0);
    checkOutput({tag, ".swapDone"}, 32'(swapDone), 32'd0);
  endtask

  initial begin
    int seq [4];
    int n;
    int pos4;
    testsRun = 0; testsFailed = 0; checkEn = 0;
    walkEn = 0; cfgWrEn = 0; cfgWrAddr = '0; cfgWrData = '0; cfgEndPtr = '0; swapReq = 0;
    resetCore = 1'b1;
    #2 resetCore = 1'b0;
    #1;

    // Reset values, then an all-IDLE table walked with a single-entry calendar.
    checkResetValues("reset");
    repeat (2) @(posedge clockCore);
    #1 resetCore = 1'b1;
    checkEn = 1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("idle.chanVld", 32'(chanVld), 32'd0);
      checkOutput("idle.calStart", 32'(calStart), 32'd1);
    end

    // Four-entry calendar 3,7,9,IDLE swapped in at the first wrap.
    seq = '{3, 7, 9, 31};
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, seq[i], 0);
    cfgEndPtr = 7'd3;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2.cfgBusy", 32'(cfgBusy), 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t2.swapDone", 32'(swapDone), 32'd1);
    checkOutput("t2.walkIdx", 32'(walkIdx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t2.chanSel", 32'(chanSel), 32'(seq[k % 4]));
      checkOutput("t2.chanVld", 32'(chanVld), 32'((k % 4) != 3));
      checkOutput("t2.calStart", 32'(calStart), 32'((k % 4) == 0));
    end

    // 96-entry calendar; swap requested at index 40 must let 41..95 play out first.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, i, i % 31, 0);
    cfgEndPtr = 7'd95;
    applyStimulus(0, 0, 0, 0, 1);
    waitSwapDone("t3a");
    applyStimulus(0, 1, 0, 5, 0);
    cfgEndPtr = 7'd3;
    n = 0;
    while (walkIdx != 7'd40 && n < 200) begin
      applyStimulus(1, 0, 0, 0, 0);
      n++;
    end
    checkOutput("t3.reach40", 32'(walkIdx), 32'd40);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t3.chanSel40", 32'(chanSel), 32'd9);
    checkOutput("t3.cfgBusy", 32'(cfgBusy), 32'd1);
    applyStimulus(1, 1, 0, 12, 0);
    checkOutput("t3.chanSel41", 32'(chanSel), 32'd10);
    for (int i = 42; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t3.oldEntry", 32'(chanSel), 32'(i % 31));
    end
    checkOutput("t3.swapDone", 32'(swapDone), 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t3.newEntry0", 32'(chanSel), 32'd5);
    checkOutput("t3.calStart", 32'(calStart), 32'd1);

    // Gaps in walkEn hold the walk; resumed entries follow on without skips.
    seq = '{5, 7, 9, 31};
    pos4 = 1;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t4.chanSel", 32'(chanSel), 32'(seq[pos4]));
      pos4 = (pos4 + 1) % 4;
      for (int g = 0; g < 2; g++) begin
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4.gapIdx", 32'(walkIdx), 32'(pos4));
        checkOutput("t4.gapVld", 32'(chanVld), 32'd0);
      end
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t4.resume", 32'(chanSel), 32'(seq[pos4]));
      pos4 = (pos4 + 1) % 4;
      checkOutput("t4.walkIdx", 32'(walkIdx), 32'(pos4));
    end

    // End pointer beyond the table clamps to the last entry; then a one-entry calendar.
    cfgEndPtr = 7'd127;
    applyStimulus(0, 0, 0, 0, 1);
    waitSwapDone("t5a");
    for (int k = 0; k < 95; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5.idx95", 32'(walkIdx), 32'd95);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5.entry95", 32'(chanSel), 32'd2);
    checkOutput("t5.wrap", 32'(walkIdx), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5.entry0", 32'(chanSel), 32'd0);
    checkOutput("t5.entry0Vld", 32'(chanVld), 32'd1);
    cfgEndPtr = 7'd0;
    applyStimulus(0, 0, 0, 0, 1);
    waitSwapDone("t5b");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t5.single", 32'(chanSel), 32'd5);
      checkOutput("t5.singleStart", 32'(calStart), 32'd1);
      checkOutput("t5.singleIdx", 32'(walkIdx), 32'd0);
    end

    // Reset while a swap is pending clears everything, tables included.
    cfgEndPtr = 7'd3;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6.pending", 32'(cfgBusy), 32'd1);
    #2 resetCore = 1'b0;
    #1;
    checkResetValues("t6.reset");
    repeat (2) @(posedge clockCore);
    #1 resetCore = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t6.chanSel", 32'(chanSel), 32'h1F);
      checkOutput("t6.chanVld", 32'(chanVld), 32'd0);
      checkOutput("t6.cfgBusy", 32'(cfgBusy), 32'd0);
    end

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
